// File: rtl/mdu_ctrl.sv
// Multiply/divide unit control for a MIPS-style pipeline: owns HI/LO, runs a
// fixed-latency busy window per MULT/DIV, and raises stall for dependent D-stage MDU ops.
module mdu_ctrl #(
   parameter int MULT_CYCLES = 5,
   parameter int DIV_CYCLES  = 10
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic [2:0]  op,
   input  logic [31:0] rs_data,
   input  logic [31:0] rt_data,
   input  logic        rd_sel,
   input  logic        mdu_use_D,
   output logic        busy,
   output logic        stall,
   output logic [31:0] hi,
   output logic [31:0] lo,
   output logic [31:0] mdu_out
);

   localparam int MAX_CYC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
   localparam int CNT_W   = $clog2(MAX_CYC + 1);

   localparam logic [0:0] S_IDLE = 1'b0;
   localparam logic [0:0] S_BUSY = 1'b1;

   localparam logic [2:0] OP_MULT  = 3'd1;
   localparam logic [2:0] OP_MULTU = 3'd2;
   localparam logic [2:0] OP_DIV   = 3'd3;
   localparam logic [2:0] OP_DIVU  = 3'd4;
   localparam logic [2:0] OP_MTHI  = 3'd5;
   localparam logic [2:0] OP_MTLO  = 3'd6;

   logic [0:0]       state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [31:0]      hi_q, hi_d, lo_q, lo_d;
   logic [31:0]      hi_tmp_q, hi_tmp_d, lo_tmp_q, lo_tmp_d;

   logic [63:0] prod_s, prod_u;
   logic [31:0] divisor, quot_s, rem_s, quot_u, rem_u;
   logic        div_zero;
   logic        op_is_md;

   assign prod_s = $signed({{32{rs_data[31]}}, rs_data}) * $signed({{32{rt_data[31]}}, rt_data});
   assign prod_u = {32'd0, rs_data} * {32'd0, rt_data};

   // A dummy divisor of 1 keeps the divider free of X on divide-by-zero.
   assign div_zero = (rt_data == 32'd0);
   assign divisor  = div_zero ? 32'd1 : rt_data;
   assign quot_s   = $signed(rs_data) / $signed(divisor);
   assign rem_s    = $signed(rs_data) % $signed(divisor);
   assign quot_u   = rs_data / divisor;
   assign rem_u    = rs_data % divisor;

   assign op_is_md = (op == OP_MULT) || (op == OP_MULTU) || (op == OP_DIV) || (op == OP_DIVU);

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      hi_d     = hi_q;
      lo_d     = lo_q;
      hi_tmp_d = hi_tmp_q;
      lo_tmp_d = lo_tmp_q;
      case (state_q)
         S_IDLE: begin
            if (start) begin
               case (op)
                  OP_MULT: begin
                     hi_tmp_d = prod_s[63:32];
                     lo_tmp_d = prod_s[31:0];
                     cnt_d    = CNT_W'(MULT_CYCLES);
                     state_d  = S_BUSY;
                  end
                  OP_MULTU: begin
                     hi_tmp_d = prod_u[63:32];
                     lo_tmp_d = prod_u[31:0];
                     cnt_d    = CNT_W'(MULT_CYCLES);
                     state_d  = S_BUSY;
                  end
                  // HI/LO cannot change while BUSY, so snapshotting them now
                  // makes a divide-by-zero commit a no-op.
                  OP_DIV: begin
                     hi_tmp_d = div_zero ? hi_q : rem_s;
                     lo_tmp_d = div_zero ? lo_q : quot_s;
                     cnt_d    = CNT_W'(DIV_CYCLES);
                     state_d  = S_BUSY;
                  end
                  OP_DIVU: begin
                     hi_tmp_d = div_zero ? hi_q : rem_u;
                     lo_tmp_d = div_zero ? lo_q : quot_u;
                     cnt_d    = CNT_W'(DIV_CYCLES);
                     state_d  = S_BUSY;
                  end
                  OP_MTHI: hi_d = rs_data;
                  OP_MTLO: lo_d = rs_data;
                  default: ;
               endcase
            end
         end
         S_BUSY: begin
            if (cnt_q == CNT_W'(1)) begin
               hi_d    = hi_tmp_q;
               lo_d    = lo_tmp_q;
               cnt_d   = '0;
               state_d = S_IDLE;
            end else begin
               cnt_d = cnt_q - CNT_W'(1);
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q  <= S_IDLE;
         cnt_q    <= '0;
         hi_q     <= '0;
         lo_q     <= '0;
         hi_tmp_q <= '0;
         lo_tmp_q <= '0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         hi_q     <= hi_d;
         lo_q     <= lo_d;
         hi_tmp_q <= hi_tmp_d;
         lo_tmp_q <= lo_tmp_d;
      end
   end

   assign busy    = (state_q == S_BUSY);
   assign stall   = mdu_use_D & (busy | (start & op_is_md));
   assign hi      = hi_q;
   assign lo      = lo_q;
   assign mdu_out = rd_sel ? hi_q : lo_q;

endmodule

// File: tb/tb_mdu_ctrl.sv
// Directed bench for mdu_ctrl: commits are checked by a monitor against a scoreboard queue.
module tb_mdu_ctrl;

   logic        clk = 1'b0;
   logic        reset;
   logic        start;
   logic [2:0]  op;
   logic [31:0] rs_data, rt_data;
   logic        rd_sel, mdu_use_D;
   logic        busy, stall;
   logic [31:0] hi, lo, mdu_out;

   int tests = 0;
   int fails = 0;

   typedef struct {
      logic [31:0] hi;
      logic [31:0] lo;
      int          len;
   } exp_t;
   exp_t sb_q[$];

   mdu_ctrl #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
      .clk(clk), .reset(reset), .start(start), .op(op),
      .rs_data(rs_data), .rt_data(rt_data), .rd_sel(rd_sel), .mdu_use_D(mdu_use_D),
      .busy(busy), .stall(stall), .hi(hi), .lo(lo), .mdu_out(mdu_out)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end else begin
         $display("ok   %s: 0x%08h", name, act);
      end
   endtask

   // Monitor: every falling edge of busy presents a result to be scored.
   int busy_len = 0;
   always @(negedge clk) begin
      if (busy === 1'b1) begin
         busy_len++;
      end else if (busy_len > 0) begin
         if (sb_q.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL sb_empty: busy window of %0d cycles with no expectation queued", busy_len);
         end else begin
            exp_t e;
            e = sb_q.pop_front();
            check("commit_hi", hi, e.hi);
            check("commit_lo", lo, e.lo);
            check("busy_len", 32'(busy_len), 32'(e.len));
         end
         busy_len = 0;
      end
   end

   task automatic issue(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
      @(posedge clk); #1;
      start = 1'b1; op = o; rs_data = a; rt_data = b;
      @(posedge clk); #1;
      start = 1'b0; op = 3'd0;
   endtask

   task automatic wait_idle();
      bit done = 1'b0;
      for (int i = 0; i < 50 && !done; i++) begin
         @(posedge clk); #1;
         if (!busy) done = 1'b1;
      end
      if (!done) begin
         tests++;
         fails++;
         $display("FAIL wait_idle: busy=%0b still high after 50 cycles, required 0", busy);
      end
      @(negedge clk);
   endtask

   task automatic push(input logic [31:0] h, input logic [31:0] l, input int n);
      exp_t e;
      e.hi = h; e.lo = l; e.len = n;
      sb_q.push_back(e);
   endtask

   initial begin
      reset = 1'b1; start = 1'b1; op = 3'd1; rs_data = 32'd5; rt_data = 32'd5;
      rd_sel = 1'b0; mdu_use_D = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b0; start = 1'b0; op = 3'd0;
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_hi", hi, 32'd0);
      check("rst_lo", lo, 32'd0);
      check("rst_mdu_out", mdu_out, 32'd0);
      check("rst_stall", 32'(stall), 32'd0);

      push(32'hFFFFFFFF, 32'hFFFFFFFE, 5);
      issue(3'd1, 32'hFFFFFFFF, 32'h00000002);
      wait_idle();

      push(32'h00000001, 32'hFFFFFFFE, 5);
      issue(3'd2, 32'hFFFFFFFF, 32'h00000002);
      wait_idle();

      push(32'hFFFFFFFF, 32'hFFFFFFFD, 10);
      issue(3'd3, 32'hFFFFFFF9, 32'd2);
      wait_idle();

      push(32'd1, 32'd3, 10);
      issue(3'd4, 32'd7, 32'd2);
      wait_idle();

      issue(3'd5, 32'h12345678, 32'd0);
      rd_sel = 1'b1; #1;
      check("mthi_mdu_out", mdu_out, 32'h12345678);
      check("mthi_busy", 32'(busy), 32'd0);
      issue(3'd6, 32'hCAFEBABE, 32'd0);
      rd_sel = 1'b0; #1;
      check("mtlo_mdu_out", mdu_out, 32'hCAFEBABE);

      push(32'h12345678, 32'hCAFEBABE, 10);
      issue(3'd3, 32'h00000064, 32'd0);
      wait_idle();

      // Stall: MTHI in IDLE does not stall, DIV does; then count stall over the busy window.
      mdu_use_D = 1'b1;
      push(32'd2, 32'd14, 10);
      @(posedge clk); #1;
      start = 1'b1; op = 3'd5; rs_data = 32'h12345678; #1;
      check("stall_mthi", 32'(stall), 32'd0);
      op = 3'd3; rs_data = 32'd100; rt_data = 32'd7; #1;
      check("stall_start", 32'(stall), 32'd1);
      @(posedge clk); #1;
      start = 1'b0; op = 3'd0;
      begin
         int st_cnt = 0;
         for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (stall) st_cnt++;
            if (i == 3) begin start = 1'b1; op = 3'd6; rs_data = 32'hDEADBEEF; end
            if (i == 4) begin start = 1'b0; op = 3'd0; end
            if (i == 5) check("mtlo_in_busy", lo, 32'hCAFEBABE);
         end
         check("stall_busy_cycles", 32'(st_cnt), 32'd10);
      end
      mdu_use_D = 1'b0;

      // Reset on the 3rd busy cycle aborts the multiply.
      push(32'd0, 32'd0, 3);
      issue(3'd1, 32'd3, 32'd4);
      @(posedge clk); #1;
      @(posedge clk); #1;
      reset = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0;
      check("abort_busy", 32'(busy), 32'd0);
      check("abort_hi", hi, 32'd0);
      check("abort_lo", lo, 32'd0);
      repeat (8) @(posedge clk);
      #1;
      check("abort_no_commit_lo", lo, 32'd0);
      check("abort_no_commit_busy", 32'(busy), 32'd0);

      issue(3'd7, 32'd555, 32'd1);
      issue(3'd0, 32'd777, 32'd1);
      check("op7_busy", 32'(busy), 32'd0);
      check("op7_hi", hi, 32'd0);
      check("op7_lo", lo, 32'd0);

      // A start while BUSY must not restart or extend the window.
      push(32'd0, 32'd42, 5);
      issue(3'd1, 32'd6, 32'd7);
      @(posedge clk); #1;
      start = 1'b1; op = 3'd4; rs_data = 32'd9; rt_data = 32'd2;
      @(posedge clk); #1;
      start = 1'b0; op = 3'd0;
      wait_idle();

      repeat (3) @(negedge clk);
      check("sb_drained", 32'(sb_q.size()), 32'd0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation exceeded 200000 time units");
      $fatal(1, "timeout");
   end

endmodule
